// File: rtl/int_branch_update_queue.sv
// Branch update queue: buffers per-lane writeback branch results into a
// one-per-cycle predictor training stream and holds the oldest redirect.
module int_branch_update_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int PTR_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          br_valid,
  input  logic [LANES*ADDR_W-1:0]   br_pc,
  input  logic [LANES*ADDR_W-1:0]   br_next_addr,
  input  logic [LANES-1:0]          br_taken,
  input  logic [LANES-1:0]          br_mispred,
  input  logic [LANES-1:0]          br_is_ax,
  input  logic [LANES*PTR_W-1:0]    br_al_ptr,
  input  logic [PTR_W-1:0]          al_head,
  input  logic                      flush,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [ADDR_W-1:0]         upd_pc,
  output logic [ADDR_W-1:0]         upd_next_addr,
  output logic                      upd_taken,
  output logic                      upd_mispred,
  output logic                      redir_valid,
  input  logic                      redir_ready,
  output logic [ADDR_W-1:0]         redir_pc,
  output logic [PTR_W-1:0]          redir_al_ptr,
  output logic [15:0]               drop_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [ADDR_W-1:0] q_next [DEPTH];
  logic [DEPTH-1:0]  q_taken;
  logic [DEPTH-1:0]  q_mispred;

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              deq;
  logic [CNT_W-1:0]  free;
  logic [CNT_W-1:0]  rank;
  logic [CNT_W-1:0]  nenq;
  logic [CNT_W-1:0]  ndrop;
  logic [LANES-1:0]  en;
  logic [IDX_W-1:0]  wptr [LANES];
  logic [LANES-1:0]  lane_taken;
  logic [LANES-1:0]  lane_mis;
  logic [16:0]       drop_sum;

  logic              cand_any;
  logic [PTR_W-1:0]  cand_age;
  logic [PTR_W-1:0]  age_i;
  logic [ADDR_W-1:0] cand_pc;
  logic [PTR_W-1:0]  cand_ptr;
  logic [PTR_W-1:0]  held_age;

  state_t            state;
  state_t            state_n;
  logic              load;

  assign upd_valid     = (count != '0);
  assign deq           = upd_valid & upd_ready;
  assign upd_pc        = q_pc[head];
  assign upd_next_addr = q_next[head];
  assign upd_taken     = q_taken[head];
  assign upd_mispred   = q_mispred[head];

  // AX branches train as taken and never count as mispredicted.
  assign lane_taken = br_taken | br_is_ax;
  assign lane_mis   = br_mispred & ~br_is_ax;

  // Slot allocation: ascending lanes take free slots, the rest are dropped.
  always_comb begin
    free  = CNT_W'(DEPTH) - count + CNT_W'(deq);
    rank  = '0;
    nenq  = '0;
    ndrop = '0;
    en    = '0;
    for (int i = 0; i < LANES; i++) begin
      wptr[i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (br_valid[i]) begin
        if (rank < free) begin
          en[i]   = 1'b1;
          wptr[i] = tail + rank[IDX_W-1:0];
          nenq    = nenq + CNT_W'(1);
        end else begin
          ndrop = ndrop + CNT_W'(1);
        end
        rank = rank + CNT_W'(1);
      end
    end
    drop_sum = {1'b0, drop_count} + 17'(ndrop);
  end

  // Training queue storage and circular pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_next[i] <= '0;
      end
      q_taken   <= '0;
      q_mispred <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (en[i]) begin
          q_pc[wptr[i]]      <= br_pc[i*ADDR_W +: ADDR_W];
          q_next[wptr[i]]    <= br_next_addr[i*ADDR_W +: ADDR_W];
          q_taken[wptr[i]]   <= lane_taken[i];
          q_mispred[wptr[i]] <= lane_mis[i];
        end
      end
      if (deq) begin
        head <= head + IDX_W'(1);
      end
      tail  <= tail + nenq[IDX_W-1:0];
      count <= count + nenq - CNT_W'(deq);
    end
  end

  // Saturating overflow-drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_sum[16]) begin
      drop_count <= 16'hFFFF;
    end else begin
      drop_count <= drop_sum[15:0];
    end
  end

  // Oldest redirect candidate by age relative to the active-list head.
  always_comb begin
    cand_any = 1'b0;
    cand_age = '0;
    cand_pc  = '0;
    cand_ptr = '0;
    age_i    = '0;
    for (int i = 0; i < LANES; i++) begin
      age_i = br_al_ptr[i*PTR_W +: PTR_W] - al_head;
      if (br_valid[i] && lane_mis[i] &&
          (!cand_any || age_i < cand_age)) begin
        cand_any = 1'b1;
        cand_age = age_i;
        cand_pc  = br_next_addr[i*ADDR_W +: ADDR_W];
        cand_ptr = br_al_ptr[i*PTR_W +: PTR_W];
      end
    end
    held_age = redir_al_ptr - al_head;
  end

  // Redirect state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Redirect next state: flush wins, then handshake, then age replacement.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cand_any) begin
            load    = 1'b1;
            state_n = PENDING;
          end
        end
        PENDING: begin
          if (redir_ready) begin
            if (cand_any) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else if (cand_any && cand_age < held_age) begin
            load = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Held redirect payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_pc     <= '0;
      redir_al_ptr <= '0;
    end else if (load) begin
      redir_pc     <= cand_pc;
      redir_al_ptr <= cand_ptr;
    end
  end

  assign redir_valid = (state == PENDING);

endmodule

// File: tb/tb_int_branch_update_queue.sv
// Scoreboard bench for int_branch_update_queue: directed vectors,
// monitors pop expected training/redirect entries on each handshake.
module tb_int_branch_update_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nx;
    logic        t;
    logic        m;
  } upd_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  ap;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld, tk, ms, ax;
  logic [31:0] pc [2];
  logic [31:0] nx [2];
  logic [6:0]  ap [2];
  logic [6:0]  al_head;
  logic        flush;
  logic        upd_valid, upd_ready;
  logic [31:0] upd_pc, upd_next_addr;
  logic        upd_taken, upd_mispred;
  logic        redir_valid, redir_ready;
  logic [31:0] redir_pc;
  logic [6:0]  redir_al_ptr;
  logic [15:0] drop_count;

  upd_t sb[$];
  rd_t  rq[$];
  int   passed = 0;
  int   total  = 0;

  int_branch_update_queue dut (
    .clk          (clk),
    .rst          (rst),
    .br_valid     (vld),
    .br_pc        ({pc[1], pc[0]}),
    .br_next_addr ({nx[1], nx[0]}),
    .br_taken     (tk),
    .br_mispred   (ms),
    .br_is_ax     (ax),
    .br_al_ptr    ({ap[1], ap[0]}),
    .al_head      (al_head),
    .flush        (flush),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_pc       (upd_pc),
    .upd_next_addr(upd_next_addr),
    .upd_taken    (upd_taken),
    .upd_mispred  (upd_mispred),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_pc     (redir_pc),
    .redir_al_ptr (redir_al_ptr),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    vld = '0; tk = '0; ms = '0; ax = '0;
    for (int i = 0; i < 2; i++) begin
      pc[i] = '0; nx[i] = '0; ap[i] = '0;
    end
  endtask

  task automatic lane(int i, logic [31:0] p, logic [31:0] n,
                      logic t, logic m, logic a, logic [6:0] ptr);
    vld[i] = 1'b1; pc[i] = p; nx[i] = n;
    tk[i] = t; ms[i] = m; ax[i] = a; ap[i] = ptr;
  endtask

  function automatic upd_t mk(logic [31:0] p, logic [31:0] n,
                              logic t, logic m);
    upd_t e;
    e.pc = p; e.nx = n; e.t = t; e.m = m;
    return e;
  endfunction

  function automatic rd_t mr(logic [31:0] p, logic [6:0] ptr);
    rd_t e;
    e.pc = p; e.ap = ptr;
    return e;
  endfunction

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    tick();
    chk("drain_empty", 96'(sb.size()), 96'd0);
    chk("drain_valid", 96'(upd_valid), 96'd0);
  endtask

  // Training stream monitor.
  always @(negedge clk) begin
    if (!rst && upd_valid && upd_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL upd_unexpected: got pc %0h expected none", upd_pc);
      end else begin
        upd_t e;
        e = sb.pop_front();
        chk("upd", {upd_pc, upd_next_addr, upd_taken, upd_mispred}, e);
      end
    end
  end

  // Redirect handshake monitor.
  always @(negedge clk) begin
    if (!rst && redir_valid && redir_ready) begin
      if (rq.size() == 0) begin
        total++;
        $display("FAIL redir_unexpected: got ptr %0d expected none",
                 redir_al_ptr);
      end else begin
        rd_t e;
        e = rq.pop_front();
        chk("redir_hs", {redir_pc, redir_al_ptr}, e);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; al_head = '0;
    upd_ready = 1'b0; redir_ready = 1'b0;
    clr();
    #12;
    chk("rst_upd_valid", 96'(upd_valid), 96'd0);
    chk("rst_redir_valid", 96'(redir_valid), 96'd0);
    chk("rst_drop", 96'(drop_count), 96'd0);
    chk("rst_upd_pc", 96'(upd_pc), 96'd0);
    chk("rst_redir_pc", 96'(redir_pc), 96'd0);
    rst = 1'b0;
    tick();

    // single branch
    upd_ready = 1'b1;
    lane(0, 32'h100, 32'h200, 1, 0, 0, 7'd0);
    sb.push_back(mk(32'h100, 32'h200, 1, 0));
    tick(); clr();
    chk("single_valid", 96'(upd_valid), 96'd1);
    chk("single_noredir", 96'(redir_valid), 96'd0);
    drain();

    // overflow with upd_ready low
    upd_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lane(0, 32'h1000 + 32'(c * 16), 32'h1040 + 32'(c * 16),
           c[0], 0, 0, 7'd0);
      lane(1, 32'h1004 + 32'(c * 16), 32'h1044 + 32'(c * 16),
           ~c[0], 0, 0, 7'd0);
      sb.push_back(mk(32'h1000 + 32'(c * 16), 32'h1040 + 32'(c * 16),
                      c[0], 0));
      sb.push_back(mk(32'h1004 + 32'(c * 16), 32'h1044 + 32'(c * 16),
                      ~c[0], 0));
      tick();
    end
    lane(0, 32'hDEAD0, 32'hDEAD4, 1, 0, 0, 7'd0);
    lane(1, 32'hBEEF0, 32'hBEEF4, 1, 0, 0, 7'd0);
    tick(); clr();
    chk("ovf_count", 96'(dut.count), 96'd8);
    chk("ovf_drop", 96'(drop_count), 96'd2);
    // full: dequeue slot reused the same cycle
    upd_ready = 1'b1;
    lane(0, 32'h2000, 32'h2040, 1, 0, 0, 7'd0);
    sb.push_back(mk(32'h2000, 32'h2040, 1, 0));
    tick(); clr();
    chk("full_reuse_count", 96'(dut.count), 96'd8);
    chk("full_reuse_drop", 96'(drop_count), 96'd2);
    drain();

    // approximate branch
    lane(0, 32'h300, 32'h304, 0, 1, 1, 7'd9);
    sb.push_back(mk(32'h300, 32'h304, 1, 0));
    tick(); clr();
    chk("ax_noredir", 96'(redir_valid), 96'd0);
    drain();

    // age select across pointer wrap
    al_head = 7'd120;
    lane(0, 32'h400, 32'h500, 0, 1, 0, 7'd5);
    lane(1, 32'h410, 32'h600, 0, 1, 0, 7'd125);
    sb.push_back(mk(32'h400, 32'h500, 0, 1));
    sb.push_back(mk(32'h410, 32'h600, 0, 1));
    tick(); clr();
    chk("age_valid", 96'(redir_valid), 96'd1);
    chk("age_ptr", 96'(redir_al_ptr), 96'd125);
    chk("age_pc", 96'(redir_pc), 96'h600);

    // held age 10; older candidate (age 3) replaces
    al_head = 7'd115;
    lane(0, 32'h420, 32'h700, 0, 1, 0, 7'd118);
    sb.push_back(mk(32'h420, 32'h700, 0, 1));
    tick(); clr();
    chk("repl_ptr", 96'(redir_al_ptr), 96'd118);
    chk("repl_pc", 96'(redir_pc), 96'h700);
    // younger candidate (age 20) is ignored
    lane(1, 32'h424, 32'h7A0, 0, 1, 0, 7'd7);
    sb.push_back(mk(32'h424, 32'h7A0, 0, 1));
    tick(); clr();
    chk("hold_ptr", 96'(redir_al_ptr), 96'd118);
    chk("hold_pc", 96'(redir_pc), 96'h700);
    // equal age does not replace
    lane(0, 32'h428, 32'h7F0, 0, 1, 0, 7'd118);
    sb.push_back(mk(32'h428, 32'h7F0, 0, 1));
    tick(); clr();
    chk("tie_pc", 96'(redir_pc), 96'h700);

    // handshake, no new candidate
    rq.push_back(mr(32'h700, 7'd118));
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("hs_idle", 96'(redir_valid), 96'd0);
    // handshake with a same-cycle candidate loads it
    al_head = 7'd0;
    lane(0, 32'h450, 32'h800, 0, 1, 0, 7'd10);
    sb.push_back(mk(32'h450, 32'h800, 0, 1));
    tick(); clr();
    chk("load_ptr", 96'(redir_al_ptr), 96'd10);
    rq.push_back(mr(32'h800, 7'd10));
    redir_ready = 1'b1;
    lane(1, 32'h460, 32'h900, 0, 1, 0, 7'd50);
    sb.push_back(mk(32'h460, 32'h900, 0, 1));
    tick(); clr();
    redir_ready = 1'b0;
    chk("hs_load_valid", 96'(redir_valid), 96'd1);
    chk("hs_load", {redir_pc, redir_al_ptr}, {32'h900, 7'd50});
    drain();

    // flush with a same-cycle candidate
    upd_ready = 1'b0;
    flush = 1'b1;
    lane(0, 32'h470, 32'hA00, 1, 1, 0, 7'd20);
    sb.push_back(mk(32'h470, 32'hA00, 1, 1));
    tick(); clr();
    flush = 1'b0;
    chk("flush_redir", 96'(redir_valid), 96'd0);
    chk("flush_count", 96'(dut.count), 96'd1);

    // reset mid-drain
    lane(0, 32'h500, 32'h580, 1, 0, 0, 7'd0);
    lane(1, 32'h504, 32'h584, 0, 1, 0, 7'd3);
    sb.push_back(mk(32'h500, 32'h580, 1, 0));
    sb.push_back(mk(32'h504, 32'h584, 0, 1));
    tick(); clr();
    chk("pre_rst_redir", 96'(redir_valid), 96'd1);
    upd_ready = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_upd_valid", 96'(upd_valid), 96'd0);
    chk("arst_upd", {upd_pc, upd_next_addr, upd_taken, upd_mispred},
        96'd0);
    chk("arst_redir_valid", 96'(redir_valid), 96'd0);
    chk("arst_redir", {redir_pc, redir_al_ptr}, 96'd0);
    chk("arst_drop", 96'(drop_count), 96'd0);
    chk("arst_count", 96'(dut.count), 96'd0);
    sb.delete();
    upd_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 96'(upd_valid), 96'd0);
    chk("redir_sb_empty", 96'(rq.size()), 96'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/int_branch_update_queue.md
# int_branch_update_queue

Consumes the per-lane branch results written back by the integer register-write stage and splits them into two outputs. One output is a buffered, one-per-cycle predictor-training stream. The other is a single held redirect request for the oldest mispredicted branch. It sits between integer writeback and the fetch unit's next-PC/predictor logic, decoupling multi-lane writeback bursts from the single-port predictor update path.

## Interface
- LANES, 2: integer issue lanes delivering branch results per cycle
- DEPTH, 8: training-queue entries (power of two, ≥ LANES)
- ADDR_W, 32: instruction address width
- PTR_W, 7: active-list pointer width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- br_valid  in  LANES  lane holds a valid, non-flushed branch result this cycle
- br_pc  in  LANES*ADDR_W  branch PC per lane
- br_next_addr  in  LANES*ADDR_W  resolved next address per lane
- br_taken  in  LANES  executed direction per lane
- br_mispred  in  LANES  lane mispredicted
- br_is_ax  in  LANES  approximate branch
- br_al_ptr  in  LANES*PTR_W  active-list pointer per lane
- al_head  in  PTR_W  active-list head pointer, for age comparison
- flush  in  1  back-end clear; cancels the pending redirect
- upd_valid  out  1  training entry available at queue head
- upd_ready  in  1  predictor accepts head entry
- upd_pc / upd_next_addr  out  ADDR_W each  head entry fields
- upd_taken / upd_mispred  out  1 each  head entry fields
- redir_valid  out  1  redirect pending
- redir_ready  in  1  fetch unit accepts redirect
- redir_pc  out  ADDR_W  redirect target (br_next_addr of chosen lane)
- redir_al_ptr  out  PTR_W  active-list pointer of chosen branch
- drop_count  out  16  saturating count of training entries dropped on overflow

## Operation
- Queue: circular buffer with head/tail pointers and a count of width log2(DEPTH)+1. First-word-fall-through: outputs are driven directly from the head register.
- Enqueue order is ascending lane index over lanes with br_valid=1.
- Free space this cycle = DEPTH − count + (upd_valid && upd_ready).
- Valid lanes beyond free space are dropped, highest lane index first. drop_count increments by the number dropped and saturates at 0xFFFF.
- AX lanes enqueue with taken forced to 1 and mispred forced to 0. They never trigger a redirect.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- Redirect candidates are lanes with br_valid && br_mispred && !br_is_ax.
- Age = (br_al_ptr − al_head) mod 2^PTR_W. Smaller is older. On equal age, the lower lane wins.
- Redirect register, IDLE→PENDING: load the oldest candidate.
- Redirect register, PENDING: replace the held entry if a new candidate is strictly older, with held age recomputed against the current al_head.
- Handshake completes when redir_valid && redir_ready:
  - with no new candidate the same cycle: go to IDLE;
  - with a new candidate the same cycle: load it and stay PENDING.
- flush=1 forces IDLE and ignores same-cycle candidates. flush does not touch the training queue, because entries are already resolved non-speculative outcomes.

## Timing
- Reset values: upd_valid=0, redir_valid=0, drop_count=0, count=0, head=tail=0; all data outputs 0.
- Latency: a branch result at edge N is visible on upd_* / redir_* after edge N, i.e. one cycle.
- Dequeue: one entry per cycle when upd_valid && upd_ready. upd_* fields hold stable while upd_valid=1 and upd_ready=0.
- redir_* holds stable while PENDING and not replaced.
- Simultaneous enqueue and dequeue at full: the dequeue slot is reusable in the same cycle.
- Empty queue: upd_valid=0 and upd_ready is ignored.
- Reset mid-operation: all state clears immediately (asynchronous). In-flight entries are lost and are not counted as drops.

## Test plan
- Single branch: lane0 valid, pc=0x100, next=0x200, taken=1, mispred=0 -> next cycle upd_valid=1, upd_pc=0x100, upd_next_addr=0x200, upd_taken=1; redir_valid stays 0.
- Overflow: upd_ready=0, both lanes valid for 4 cycles then 1 more cycle with DEPTH=8 -> count=8, drop_count=2, lane order preserved on drain (8 pops, FIFO order).
- Age select: al_head=120; lane0 mispred al_ptr=5, lane1 mispred al_ptr=125 -> redir_al_ptr=125 (age 5 < age 13), redir_pc = lane1 next_addr.
- Replacement/hold: PENDING with age 10, redir_ready=0; new candidate age 3 -> replaced; new candidate age 20 -> held unchanged.
- AX: lane0 is_ax=1, mispred=1, taken=0 -> upd_taken=1, upd_mispred=0, redir_valid=0.
- Flush and reset: PENDING plus flush with a same-cycle candidate -> redir_valid=0 next cycle, queue count unchanged. Assert rst mid-drain -> all outputs 0 without waiting for a clock edge.
